// File: rtl/alu_mc_pkg.sv
// Shared opcodes, FSM state and flag bundle for the multi-cycle ALU.
package alu_mc_pkg;

  localparam logic [3:0] opAnd   = 4'b0000;
  localparam logic [3:0] opOr    = 4'b0001;
  localparam logic [3:0] opAdd   = 4'b0010;
  localparam logic [3:0] opLsl   = 4'b0011;
  localparam logic [3:0] opLsr   = 4'b0100;
  localparam logic [3:0] opMul   = 4'b0101;
  localparam logic [3:0] opSub   = 4'b0110;
  localparam logic [3:0] opPassB = 4'b0111;

  typedef enum logic {IDLE, MULT} stateT;

  typedef struct packed {
    logic zero;
    logic negative;
    logic carry;
    logic overflow;
  } flagsT;

endpackage

// File: rtl/alu_mc_mul.sv
// Iterative shift-add multiplier: one partial-product step per cycle, WIDTH steps.
// product/done are valid combinationally during the final step so the caller registers them on that edge.
module alu_mc_mul #(
  parameter int WIDTH = 64
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             go,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);
  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] lastStep = SHW'(WIDTH - 1);

  logic [WIDTH-1:0] mcand, mplier, acc, stepAcc;
  logic [SHW-1:0]   cnt;
  logic             busy;

  assign stepAcc = acc + (mplier[0] ? mcand : '0);
  assign product = stepAcc;
  assign done    = busy && (cnt == lastStep);

  always_ff @(posedge CLK) begin
    if (Reset) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
    end else if (go) begin
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
      cnt    <= '0;
      busy   <= 1'b1;
    end else if (busy) begin
      acc    <= stepAcc;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with Start/Ready handshake and registered result/flags.
// Define ALU_MUL_EN to build in the iterative multiplier (opcode 0101); otherwise 0101 is illegal.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Start,
  input  logic [3:0]       ALUCtrl,
  input  logic [WIDTH-1:0] BusA,
  input  logic [WIDTH-1:0] BusB,
  output logic             Ready,
  output logic             Valid,
  output logic [WIDTH-1:0] BusW,
  output logic             Zero,
  output logic             Negative,
  output logic             Carry,
  output logic             Overflow
);
  localparam int SHW = $clog2(WIDTH);

  logic             issue, isMul;
  logic [WIDTH:0]   addSum, subSum;
  logic [WIDTH-1:0] aluRes;
  logic             aluC, aluV;
  flagsT            flags;

  assign issue = Start && Ready;
  assign {Zero, Negative, Carry, Overflow} = flags;

  always_comb begin
    addSum = {1'b0, BusA} + {1'b0, BusB};
    subSum = {1'b0, BusA} + {1'b0, ~BusB} + (WIDTH+1)'(1);
    aluRes = '0;
    aluC   = 1'b0;
    aluV   = 1'b0;
    // Illegal codes (and MUL, which takes its own path) fall to the zero default.
    case (ALUCtrl)
      opAnd:   aluRes = BusA & BusB;
      opOr:    aluRes = BusA | BusB;
      opAdd: begin
        aluRes = addSum[WIDTH-1:0];
        aluC   = addSum[WIDTH];
        aluV   = (BusA[WIDTH-1] == BusB[WIDTH-1]) && (aluRes[WIDTH-1] != BusA[WIDTH-1]);
      end
      opLsl:   aluRes = BusA << BusB[SHW-1:0];
      opLsr:   aluRes = BusA >> BusB[SHW-1:0];
      opSub: begin
        aluRes = subSum[WIDTH-1:0];
        aluC   = subSum[WIDTH];
        aluV   = (BusA[WIDTH-1] != BusB[WIDTH-1]) && (aluRes[WIDTH-1] != BusA[WIDTH-1]);
      end
      opPassB: aluRes = BusB;
      default: aluRes = '0;
    endcase
  end

`ifdef ALU_MUL_EN
  stateT            state, nextState;
  logic             mulDone;
  logic [WIDTH-1:0] mulProduct;

  assign isMul = (ALUCtrl == opMul);
  assign Ready = (state == IDLE);

  always_ff @(posedge CLK) begin
    if (Reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (issue && isMul) nextState = MULT;
      MULT:    if (mulDone) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  alu_mc_mul #(.WIDTH(WIDTH)) uMul (
    .CLK    (CLK),
    .Reset  (Reset),
    .go     (issue && isMul),
    .a      (BusA),
    .b      (BusB),
    .done   (mulDone),
    .product(mulProduct)
  );
`else
  assign isMul = 1'b0;
  assign Ready = 1'b1;
`endif

  always_ff @(posedge CLK) begin
    if (Reset) begin
      BusW  <= '0;
      flags <= '0;
      Valid <= 1'b0;
    end else begin
      Valid <= 1'b0;
      if (issue && !isMul) begin
        BusW  <= aluRes;
        flags <= '{zero: (aluRes == '0), negative: aluRes[WIDTH-1], carry: aluC, overflow: aluV};
        Valid <= 1'b1;
      end
`ifdef ALU_MUL_EN
      else if (mulDone) begin
        BusW  <= mulProduct;
        flags <= '{zero: (mulProduct == '0), negative: mulProduct[WIDTH-1], carry: 1'b0, overflow: 1'b0};
        Valid <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: vector table plus scoreboard-checked multi-cycle sequences.
module tb_alu_mc;
  localparam int W = 64;
  localparam logic [3:0] cAnd = 4'b0000, cOr = 4'b0001, cAdd = 4'b0010, cLsl = 4'b0011;
  localparam logic [3:0] cLsr = 4'b0100, cMul = 4'b0101, cSub = 4'b0110, cPassB = 4'b0111;

  logic         CLK = 1'b0;
  logic         Reset, Start;
  logic [3:0]   ALUCtrl;
  logic [W-1:0] BusA, BusB, BusW;
  logic         Ready, Valid, Zero, Negative, Carry, Overflow;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a, b, w;
    logic [3:0]   f;  // {Zero, Negative, Carry, Overflow}
  } vecT;

  typedef struct {
    logic [W-1:0] w;
    logic [3:0]   f;
    int           due;
  } sbT;

  vecT vecs[$];
  sbT  sb[$];
  int  errors = 0, checks = 0, cyc = 0;

  alu_mc #(.WIDTH(W)) dut (
    .CLK(CLK), .Reset(Reset), .Start(Start), .ALUCtrl(ALUCtrl),
    .BusA(BusA), .BusB(BusB), .Ready(Ready), .Valid(Valid), .BusW(BusW),
    .Zero(Zero), .Negative(Negative), .Carry(Carry), .Overflow(Overflow)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic addVec(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] w, input logic [3:0] f);
    vecT v;
    v.op = op; v.a = a; v.b = b; v.w = w; v.f = f;
    vecs.push_back(v);
  endtask

  // Called at a negedge; applies inputs for the next edge and returns at the following negedge.
  task automatic drive(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit push, input logic [W-1:0] ew, input logic [3:0] ef, input int lat);
    sbT e;
    Start = 1'b1; ALUCtrl = op; BusA = a; BusB = b;
    if (push) begin
      chk("ready_at_issue", W'(Ready), W'(1));
      e.w = ew; e.f = ef; e.due = cyc + lat;
      sb.push_back(e);
    end
    @(negedge CLK);
  endtask

  task automatic waitReady(input int lim);
    bit ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      if (Ready === 1'b1) begin ok = 1'b1; break; end
      @(negedge CLK);
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL ready_timeout: got Ready=0 for %0d cycles expected Ready=1", lim);
    end
  endtask

  task automatic drain(input int lim);
    for (int i = 0; i < lim && sb.size() != 0; i++) @(negedge CLK);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending results expected 0", sb.size());
    end
  endtask

  task automatic chkZeroOuts(input string tag);
    chk({tag, "_busw"},  BusW, '0);
    chk({tag, "_valid"}, W'(Valid), '0);
    chk({tag, "_flags"}, W'({Zero, Negative, Carry, Overflow}), '0);
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; ALUCtrl = '0; BusA = '0; BusB = '0;

    fork
      forever @(posedge CLK) cyc++;
      forever begin
        @(negedge CLK);
        if (Valid === 1'b1) begin
          if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_valid: got Valid=1 at cycle %0d expected none", cyc);
          end else begin
            sbT e;
            e = sb.pop_front();
            chk("busw", BusW, e.w);
            chk("flags", W'({Zero, Negative, Carry, Overflow}), W'(e.f));
            chk("latency", W'(cyc), W'(e.due));
          end
        end
      end
    join_none

    // Reset values
    repeat (2) @(negedge CLK);
    chkZeroOuts("reset");
    Reset = 1'b0;
    @(negedge CLK);
    chk("ready_after_reset", W'(Ready), W'(1));

    addVec(cAdd,   64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 4'b1010);
    addVec(cSub,   64'h8000_0000_0000_0000, 64'h1, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0011);
    addVec(cLsl,   64'h1, 64'h43, 64'h8, 4'b0000);
    addVec(cLsr,   64'h80, 64'h7, 64'h1, 4'b0000);
    addVec(cAnd,   64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 64'hF000_F000_F000_F000, 4'b0100);
    addVec(cOr,    64'h0F, 64'hF0, 64'hFF, 4'b0000);
    addVec(4'hF,   64'h1234, 64'h5678, 64'h0, 4'b1000);
    addVec(cAdd,   64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 64'h8000_0000_0000_0000, 4'b0101);
    addVec(cSub,   64'h5, 64'h7, 64'hFFFF_FFFF_FFFF_FFFE, 4'b0100);
    addVec(cSub,   64'h7, 64'h7, 64'h0, 4'b1010);
    addVec(cPassB, 64'h123, 64'hDEAD, 64'hDEAD, 4'b0000);
    addVec(cLsl,   64'hABC, 64'h0, 64'hABC, 4'b0000);
    addVec(cLsr,   64'h8000_0000_0000_0000, 64'd63, 64'h1, 4'b0000);
    addVec(cLsr,   64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 4'b0000);
    addVec(4'b1000, 64'h5, 64'h5, 64'h0, 4'b1000);
    addVec(cAdd,   64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 4'b0110);
    addVec(cSub,   64'h0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0100);
`ifndef ALU_MUL_EN
    addVec(cMul,   64'h3, 64'h4, 64'h0, 4'b1000);
`endif

    // Issued back to back: one Valid per cycle
    foreach (vecs[i]) drive(vecs[i].op, vecs[i].a, vecs[i].b, 1'b1, vecs[i].w, vecs[i].f, 1);
    Start = 1'b0;
    drain(10);

    // Reset mid-stream clears a non-zero result
    drive(cAdd, 64'h3, 64'h4, 1'b1, 64'h7, 4'b0000, 1);
    Start = 1'b0; Reset = 1'b1;
    repeat (2) @(negedge CLK);
    chkZeroOuts("midreset");
    Reset = 1'b0;
    @(negedge CLK);
    chk("ready_after_midreset", W'(Ready), W'(1));

    // Start coincident with Reset is dropped
    Reset = 1'b1;
    drive(cAdd, 64'h3, 64'h4, 1'b0, '0, '0, 0);
    Reset = 1'b0; Start = 1'b0;
    repeat (3) @(negedge CLK);
    chk("start_with_reset_busw", BusW, '0);

`ifdef ALU_MUL_EN
    begin
      logic [W-1:0] ra, rb, rp;
      drive(cMul, 64'd12345, 64'd678, 1'b1, 64'd8369910, 4'b0000, W + 1);
      Start = 1'b0;
      chk("mul_ready_busy0", W'(Ready), '0);
      repeat (5) @(negedge CLK);
      chk("mul_ready_busy1", W'(Ready), '0);
      // Ignored: arrives while busy, must not produce a later Valid
      drive(cAdd, 64'h1, 64'h1, 1'b0, '0, '0, 0);
      Start = 1'b0;
      chk("mul_ready_busy2", W'(Ready), '0);
      waitReady(100);
      // Issue in the same cycle as the MUL Valid
      drive(cAdd, 64'h2, 64'h3, 1'b1, 64'h5, 4'b0000, 1);
      Start = 1'b0;

      for (int k = 0; k < 2; k++) begin
        ra = {32'($urandom), 32'($urandom)};
        rb = {32'($urandom), 32'($urandom)};
        rp = ra * rb;
        drive(cMul, ra, rb, 1'b1, rp, {rp == '0, rp[W-1], 2'b00}, W + 1);
        Start = 1'b0;
        @(negedge CLK);
        waitReady(100);
      end
      drive(cMul, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'h1, 4'b0000, W + 1);
      Start = 1'b0;
      @(negedge CLK);
      waitReady(100);
      drain(10);

      // Reset 30 cycles into a MUL aborts it
      drive(cMul, 64'd5, 64'd7, 1'b0, '0, '0, 0);
      Start = 1'b0;
      repeat (29) @(negedge CLK);
      Reset = 1'b1;
      @(negedge CLK);
      Reset = 1'b0;
      chkZeroOuts("mul_abort");
      @(negedge CLK);
      chk("mul_abort_ready", W'(Ready), W'(1));
      repeat (80) @(negedge CLK);
      chk("mul_abort_busw", BusW, '0);
    end
`endif

    drain(200);
    repeat (2) @(negedge CLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
